// File: rtl/rv_shift_pkg.sv
// rv_shift_pkg: shared decode constants, op enum and result record for the shift controller
package rv_shift_pkg;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ILL} op_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } res_t;

    function automatic op_e decode(input logic [2:0] funct3, input logic funct7b5);
        if (funct3 == F3_SLL && !funct7b5) return OP_SLL;
        if (funct3 == F3_SR) return funct7b5 ? OP_SRA : OP_SRL;
        return OP_ILL;
    endfunction
endpackage

// File: rtl/rv_res_fifo.sv
// rv_res_fifo: synchronous result FIFO with registered head, flush and occupancy count
module rv_res_fifo
    import rv_shift_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  res_t                         din_i,
    output res_t                         head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    res_t          mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i && count_o != '0;
    assign do_push = push_i && (count_o != CW'(DEPTH) || do_pop);
    assign head_o  = mem[rp];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp      <= '0;
            rp      <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            wp      <= '0;
            rp      <= '0;
            count_o <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din_i;
                wp      <= inc(wp);
            end
            if (do_pop) rp <= inc(rp);
            count_o <= count_o + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/rv_shift_ctrl.sv
// rv_shift_ctrl: issue/writeback controller wrapped around the 2-cycle barrel shifter
module rv_shift_ctrl
    import rv_shift_pkg::*;
#(
    parameter int RES_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [31:0] rs1_data_i,
    input  logic [4:0]  shamt_i,
    input  logic [4:0]  rd_i,
    input  logic        flush_i,
    output logic        sh_ce_o,
    output logic [31:0] sh_d_o,
    output logic [4:0]  sh_s_o,
    output logic        sh_right_o,
    output logic        sh_sig_o,
    input  logic        sh_ce_i,
    input  logic [31:0] sh_d_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        wb_err_o,
    output logic        proto_err_o
);
    localparam int CW = $clog2(RES_DEPTH + 1);

    op_e           op;
    logic          legal, accept, pop, push;
    logic          slot_v, slot_err, flush_q;
    logic [4:0]    slot_rd;
    logic [CW-1:0] count;
    logic [CW:0]   occ;
    res_t          din, head;

    assign op         = decode(funct3_i, funct7b5_i);
    assign legal      = op != OP_ILL;
    assign occ        = {1'b0, count} + (CW+1)'(slot_v);
    assign pop        = wb_valid_o & wb_ready_i;
    assign ready_o    = (occ < (CW+1)'(RES_DEPTH)) | ((occ == (CW+1)'(RES_DEPTH)) & pop);
    assign accept     = valid_i & ready_o & ~flush_i & ~rst_i;
    assign sh_ce_o    = accept & legal;
    assign sh_d_o     = rs1_data_i;
    assign sh_s_o     = shamt_i;
    assign sh_right_o = op == OP_SRL || op == OP_SRA;
    assign sh_sig_o   = op == OP_SRA;
    assign push       = slot_v & ~flush_i;
    assign din        = '{rd: slot_rd, data: slot_err ? 32'd0 : sh_d_i, err: slot_err};
    assign wb_valid_o = count != '0;
    assign {wb_rd_o, wb_data_o, wb_err_o} = head;

    rv_res_fifo #(.DEPTH(RES_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (din),
        .head_o  (head),
        .count_o (count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_v      <= 1'b0;
            slot_rd     <= '0;
            slot_err    <= 1'b0;
            flush_q     <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            slot_v   <= accept;
            slot_rd  <= rd_i;
            slot_err <= ~legal;
            flush_q  <= flush_i;
            if (sh_ce_i != (slot_v & ~slot_err) && !(flush_q && sh_ce_i)) proto_err_o <= 1'b1;
        end
    end
endmodule

// File: doc/rv_shift_ctrl.md
Name: rv_shift_ctrl

Overview:
- Issue/writeback controller sitting directly upstream and downstream of the 2-cycle barrel shifter (rv_shifter) in the RV32I execute stage.
- Decodes SLL/SRL/SRA (register and immediate forms) from the issue stage and drives the shifter's ce/d/s/right/sig inputs.
- Pairs each shifter result with its destination tag and buffers results in a credit-managed FIFO toward writeback.
- Back-pressures issue so no shifter result is ever dropped.

Parameters:
- RES_DEPTH, 2, result FIFO entries; legal values are 2..8. Must cover the 1 in-flight slot plus 1 buffered result for full throughput.

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  issue request
- ready_o  out  1  controller can accept an issue this cycle
- funct3_i  in  3  instruction funct3
- funct7b5_i  in  1  instruction bit 30 (arith select)
- rs1_data_i  in  32  operand to shift
- shamt_i  in  5  shift amount, already selected by issue (rs2[4:0] or imm[24:20])
- rd_i  in  5  destination register
- flush_i  in  1  pipeline flush; discards in-flight and buffered results
- sh_ce_o  out  1  shifter ce_i
- sh_d_o  out  32  shifter d_i
- sh_s_o  out  5  shifter s_i
- sh_right_o  out  1  shifter right_i
- sh_sig_o  out  1  shifter sig_i
- sh_ce_i  in  1  shifter ce_o
- sh_d_i  in  32  shifter d_o
- wb_valid_o  out  1  result available
- wb_ready_i  in  1  writeback consumes result
- wb_rd_o  out  5  result destination
- wb_data_o  out  32  result value
- wb_err_o  out  1  illegal encoding; data is 0
- proto_err_o  out  1  sticky; sh_ce_i disagreed with the expected in-flight slot

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: ready_o=1, sh_ce_o=0, wb_valid_o=0, wb_rd_o=0, wb_data_o=0, wb_err_o=0, proto_err_o=0. FIFO is emptied, the in-flight slot is cleared and the credit count is 0.
- Decode:
  - funct3=001 and funct7b5=0 -> SLL (right=0, sig=0).
  - funct3=101 and funct7b5=0 -> SRL (right=1, sig=0).
  - funct3=101 and funct7b5=1 -> SRA (right=1, sig=1).
  - Anything else is illegal: the op is still accepted, sh_ce_o stays 0, and it completes with err=1 and data=0.
- Accept: accept = valid_i & ready_o & !flush_i.
- Shifter drive: sh_ce_o = accept & legal, combinational in the accept cycle. sh_d_o=rs1_data_i and sh_s_o=shamt_i pass straight through.
- In-flight slot: registered {v, rd, err}, loaded with accept. The slot completes in the next cycle.
- Completion:
  - A legal op writes {rd, sh_d_i, 0} into the FIFO.
  - An illegal op writes {rd, 0, 1}.
  - FIFO write happens at the end of the cycle after accept.
  - Latency: accept in cycle N -> wb_valid_o=1 earliest in N+2.
- Shifter protocol check: in any cycle, sh_ce_i must equal (slot.v & !slot.err). A mismatch sets proto_err_o, which holds until reset. On a mismatch the slot still completes using sh_d_i.
- Credits:
  - occ = fifo_count + slot.v.
  - ready_o = (occ < RES_DEPTH) | (occ == RES_DEPTH & wb_valid_o & wb_ready_i). A same-cycle pop frees a credit.
  - ready_o is independent of valid_i.
- FIFO:
  - Pop on wb_valid_o & wb_ready_i.
  - wb_* come directly from the FIFO head register (registered outputs) and hold stable while wb_valid_o=1 & !wb_ready_i.
  - Simultaneous push and pop when full is legal. Simultaneous push and pop when empty yields valid the next cycle (no bypass).
- Flush:
  - Synchronous. In the flush cycle: accept is blocked, the slot is cleared, the FIFO is emptied, and a pop in that cycle is discarded.
  - The next cycle has wb_valid_o=0 and ready_o=1.
  - A shifter result returning after the flush is ignored and is not a protocol error.
- Reset mid-operation: identical to flush, plus proto_err_o is cleared. The shifter is reset by the same rst_i.
- Widths: pointers are $clog2(RES_DEPTH) bits and wrap modulo RES_DEPTH. The count is $clog2(RES_DEPTH+1) bits.

Decomposition:
- Package rv_shift_pkg:
  - funct3 constants F3_SLL=3'b001 and F3_SR=3'b101.
  - Op enum {OP_SLL, OP_SRL, OP_SRA, OP_ILL}.
  - Result struct {rd[4:0], data[31:0], err}.
  - decode function returning the op enum.
- Sub-module rv_res_fifo: synchronous FIFO of result structs, with push/pop/flush/count and a registered head.

Test Plan:
- SLL: rs1=0x0000_0001, shamt=31, rd=5, wb_ready=1 -> wb_valid in N+2 with data 0x8000_0000, rd=5, err=0.
- SRA then SRL, back-to-back on rs1=0x8000_00F0 with shamt=4 -> results in order: 0xF800_000F, then 0x0800_000F. ready_o stays 1 throughout.
- Illegal op (funct3=000) -> sh_ce_o stays 0; wb shows err=1, data=0, correct rd, in issue order behind earlier ops.
- Backpressure: wb_ready=0 with continuous valid_i -> exactly RES_DEPTH (2) ops accepted, ready_o=0, wb outputs stable. Raising wb_ready then gives one pop per cycle and ready_o=1 in the same cycle as the first pop.
- Flush with one op in flight and one buffered -> next cycle wb_valid_o=0, ready_o=1, no spurious output later, proto_err_o=0.
- Protocol check: force sh_ce_i=1 with no op in flight -> proto_err_o=1 from the next cycle until rst_i.
